// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and 7-segment patterns for the stopwatch controller
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Active-low {a..g}
    localparam logic [6:0] SEG_ZERO = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        if (d > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_DIGIT[d];
    endfunction

endpackage

// File: rtl/sw_bcd_digit.sv
// rtl/sw_bcd_digit.sv - one mod-10 BCD digit with synchronous clear and ripple carry
module sw_bcd_digit (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    assign carry = inc & (q == 4'd9);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (inc) begin
            q <= carry ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch run/pause/clear sequencing, SS.hh BCD count, seg drive, scan enable
// Build option: define STOPWATCH_LAP_EN for the lap-hold display freeze.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100,
    parameter int SCAN_HZ = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_ss,
    input  logic        btn_clr,
    output logic [6:0]  seg0,
    output logic [6:0]  seg1,
    output logic [6:0]  seg2,
    output logic [6:0]  seg3,
    output logic        scan_en,
    output logic        running,
    output logic [15:0] bcd
);

    localparam int DIV_T = CLK_HZ / TICK_HZ;
    localparam int DIV_S = CLK_HZ / SCAN_HZ;
    localparam int TW    = $clog2(DIV_T);
    localparam int SW    = $clog2(DIV_S);

    state_t         state;
    state_t         state_next;
    logic           in_idle;
    logic [2:0]     ss_sync;
    logic [2:0]     clr_sync;
    logic           ss_p;
    logic           clr_p;
    logic           clr_eff;
    logic           seg_load;
    logic [TW-1:0]  tcnt;
    logic           tick;
    logic [SW-1:0]  scnt;
    logic [3:0]     d0, d1, d2, d3;
    logic           c0, c1, c2;
    logic           carry_unused;

    // Two sync stages, a third for edge history; the pulse is registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_sync  <= 3'd0;
            clr_sync <= 3'd0;
            ss_p     <= 1'b0;
            clr_p    <= 1'b0;
        end else begin
            ss_sync  <= {ss_sync[1:0], btn_ss};
            clr_sync <= {clr_sync[1:0], btn_clr};
            ss_p     <= ss_sync[1] & ~ss_sync[2];
            clr_p    <= clr_sync[1] & ~clr_sync[2];
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_hold;
    logic lap_toggle;

    assign lap_toggle = clr_p && (state == RUN);
    assign clr_eff    = clr_p && (state != RUN);
    assign seg_load   = ~lap_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_hold <= 1'b0;
        end else if (clr_eff) begin
            lap_hold <= 1'b0;
        end else if (lap_toggle) begin
            lap_hold <= ~lap_hold;
        end
    end
`else
    assign clr_eff  = clr_p;
    assign seg_load = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clr_eff) begin
            state_next = IDLE;
        end else if (ss_p) begin
            case (state)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state == RUN);
        in_idle = (state == IDLE);
    end

    // Held in PAUSE so a resume finishes the interrupted 10 ms slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if (in_idle) begin
            tcnt <= '0;
        end else if (running) begin
            tcnt <= tick ? '0 : tcnt + TW'(1);
        end
    end

    assign tick = running && (tcnt == TW'(DIV_T - 1));

    sw_bcd_digit u_d0 (.clk(clk), .reset(reset), .clr(clr_eff), .inc(tick), .q(d0), .carry(c0));
    sw_bcd_digit u_d1 (.clk(clk), .reset(reset), .clr(clr_eff), .inc(c0),   .q(d1), .carry(c1));
    sw_bcd_digit u_d2 (.clk(clk), .reset(reset), .clr(clr_eff), .inc(c1),   .q(d2), .carry(c2));
    sw_bcd_digit u_d3 (.clk(clk), .reset(reset), .clr(clr_eff), .inc(c2),   .q(d3), .carry(carry_unused));

    assign bcd = {d3, d2, d1, d0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg0 <= SEG_ZERO;
            seg1 <= SEG_ZERO;
            seg2 <= SEG_ZERO;
            seg3 <= SEG_ZERO;
        end else if (seg_load) begin
            seg0 <= seg_decode(d0);
            seg1 <= seg_decode(d1);
            seg2 <= seg_decode(d2);
            seg3 <= seg_decode(d3);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scnt    <= '0;
            scan_en <= 1'b0;
        end else begin
            scan_en <= (scnt == SW'(DIV_S - 1));
            scnt    <= (scnt == SW'(DIV_S - 1)) ? '0 : scnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl against an elapsed-run-time model
module tb_stopwatch_ctrl;

    localparam int DIV_T  = 10;
    localparam int SCAN_P = 4;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_ss = 1'b0;
    logic        btn_clr = 1'b0;
    logic [6:0]  seg0, seg1, seg2, seg3;
    logic        scan_en, running;
    logic [15:0] bcd;

    logic        reset_f = 1'b1;
    logic        btn_ss_f = 1'b0;
    logic        btn_clr_f = 1'b0;
    logic [6:0]  seg_unused0, seg_unused1, seg_unused2, seg_unused3;
    logic        scan_unused, running_f;
    logic [15:0] bcd_f;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .SCAN_HZ(250)) u_dut (
        .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_clr(btn_clr),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
        .scan_en(scan_en), .running(running), .bcd(bcd)
    );

    // Fast-tick copy reaches 99.99 in ~20k cycles for the wrap check.
    stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(500), .SCAN_HZ(500)) u_fast (
        .clk(clk), .reset(reset_f), .btn_ss(btn_ss_f), .btn_clr(btn_clr_f),
        .seg0(seg_unused0), .seg1(seg_unused1), .seg2(seg_unused2), .seg3(seg_unused3),
        .scan_en(scan_unused), .running(running_f), .bcd(bcd_f)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b0001100;
        endcase
    endfunction

    function automatic int count_of(input int rc);
        return (rc / DIV_T) % 10000;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Model: mode 0=idle 1=run 2=pause; count = run cycles since last clear / DIV_T.
    int         m_mode = 0;
    int         m_rc = 0;
    int         m_shown = 0;
    bit         m_lap = 1'b0;
    int         m_edges = 0;
    logic [4:0] h_ss = '0;
    logic [4:0] h_clr = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode  <= 0;
            m_rc    <= 0;
            m_shown <= 0;
            m_lap   <= 1'b0;
            m_edges <= 0;
            h_ss    <= '0;
            h_clr   <= '0;
        end else begin
            logic [4:0] hs, hc;
            bit ss_e, clr_e, run_now, lap_tog, clear;
            hs = {h_ss[3:0], btn_ss};
            hc = {h_clr[3:0], btn_clr};
            ss_e    = hs[3] & ~hs[4];
            clr_e   = hc[3] & ~hc[4];
            run_now = (m_mode == 1);
            lap_tog = LAP && clr_e && run_now;
            clear   = clr_e && !lap_tog;
            h_ss    <= hs;
            h_clr   <= hc;
            m_edges <= m_edges + 1;
            if (!m_lap) m_shown <= count_of(m_rc);
            if (clear) begin
                m_mode <= 0;
                m_rc   <= 0;
                m_lap  <= 1'b0;
            end else begin
                m_rc <= run_now ? m_rc + 1 : m_rc;
                if (lap_tog) m_lap <= !m_lap;
                if (ss_e) m_mode <= run_now ? 2 : 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("bcd", bcd, to_bcd(count_of(m_rc)));
            chk("running", 16'(running), 16'(m_mode == 1));
            chk("scan_en", 16'(scan_en), 16'(m_edges > 0 && (m_edges % SCAN_P) == 0));
            chk("seg0", 16'(seg0), 16'(pat(m_shown % 10)));
            chk("seg1", 16'(seg1), 16'(pat((m_shown / 10) % 10)));
            chk("seg2", 16'(seg2), 16'(pat((m_shown / 100) % 10)));
            chk("seg3", 16'(seg3), 16'(pat((m_shown / 1000) % 10)));
        end
    end

    logic [15:0] prev_f = '0;
    bit          wrap_seen = 1'b0;

    always @(negedge clk) begin
        if (!reset_f) begin
            if (!wrap_seen && prev_f == 16'h9999 && bcd_f != prev_f) begin
                chk("wrap_bcd", bcd_f, 16'h0000);
                chk("wrap_running", 16'(running_f), 16'd1);
                wrap_seen <= 1'b1;
            end
            prev_f <= bcd_f;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_bcd(input logic [15:0] target, input int limit, input string name);
        int n = 0;
        while (bcd !== target && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, bcd, target);
    endtask

    task automatic press_ss();
        btn_ss = 1'b1;
        repeat (6) @(negedge clk);
        btn_ss = 1'b0;
    endtask

    initial begin
        int n;
        int pulses;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        reset_f = 1'b0;
        @(negedge clk);
        btn_ss_f = 1'b1;
        repeat (6) @(negedge clk);
        btn_ss_f = 1'b0;

        repeat (50) @(negedge clk);
        chk("idle_bcd", bcd, 16'h0000);
        chk("idle_running", 16'(running), 16'd0);
        chk("idle_seg0", 16'(seg0), 16'(7'b0000001));
        chk("idle_seg3", 16'(seg3), 16'(7'b0000001));
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (scan_en) pulses++;
        end
        chk("idle_scan_count", 16'(pulses), 16'd10);

        btn_ss = 1'b1;
        repeat (3) @(negedge clk);
        chk("start_lat3", 16'(running), 16'd0);
        @(negedge clk);
        chk("start_lat4", 16'(running), 16'd1);
        repeat (2) @(negedge clk);
        btn_ss = 1'b0;
        repeat (368) @(negedge clk);
        chk("run_bcd_37", bcd, 16'h0037);
        @(negedge clk);
        chk("seg1_is_3", 16'(seg1), 16'(7'b0000110));
        chk("seg0_is_7", 16'(seg0), 16'(7'b0001111));

        wait_bcd(16'h0099, 1000, "reach_0099");
        n = 0;
        while (bcd == 16'h0099 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("carry_0100", bcd, 16'h0100);

        apply_reset();
        press_ss();
        wait_bcd(16'h0012, 300, "reach_0012");
        press_ss();
        chk("pause_running", 16'(running), 16'd0);
        repeat (200) @(negedge clk);
        chk("pause_hold", bcd, 16'h0012);
        press_ss();
        repeat (3) @(negedge clk);
        chk("resume_before", bcd, 16'h0012);
        @(negedge clk);
        chk("resume_tick", bcd, 16'h0013);

`ifndef STOPWATCH_LAP_EN
        btn_ss = 1'b1;
        btn_clr = 1'b1;
        repeat (6) @(negedge clk);
        btn_ss = 1'b0;
        btn_clr = 1'b0;
        chk("both_bcd", bcd, 16'h0000);
        chk("both_running", 16'(running), 16'd0);
`else
        apply_reset();
        btn_ss = 1'b1;
        repeat (6) @(negedge clk);
        btn_ss = 1'b0;
        repeat (44) @(negedge clk);
        btn_clr = 1'b1;
        repeat (6) @(negedge clk);
        btn_clr = 1'b0;
        repeat (64) @(negedge clk);
        chk("lap_frozen_seg0", 16'(seg0), 16'(7'b1001100));
        chk("lap_live_bcd", bcd, 16'h0011);
        btn_clr = 1'b1;
        repeat (6) @(negedge clk);
        btn_clr = 1'b0;
        chk("lap_release_seg0", 16'(seg0), 16'(7'b0010010));
        chk("lap_release_seg1", 16'(seg1), 16'(7'b1001111));
`endif

        apply_reset();
        press_ss();
        repeat (30) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("areset_bcd", bcd, 16'h0000);
        chk("areset_running", 16'(running), 16'd0);
        chk("areset_scan", 16'(scan_en), 16'd0);
        chk("areset_seg0", 16'(seg0), 16'(7'b0000001));
        chk("areset_seg3", 16'(seg3), 16'(7'b0000001));
        @(negedge clk);
        #2 reset = 1'b0;

        repeat (4000) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 4) btn_ss = ~btn_ss;
            if ($urandom_range(0, 199) < 2) btn_clr = ~btn_clr;
        end
        btn_ss = 1'b0;
        btn_clr = 1'b0;

        n = 0;
        while (!wrap_seen && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_seen", 16'(wrap_seen), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
